// File: rtl/core_preempt_unit_if.sv
// Data-memory request/acknowledge bus between the preempt unit (master)
// and the data memory (slave).
interface core_preempt_unit_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   logic              req;
   logic              wen;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ack;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req, wen, addr, wdata,
      input  ack, rdata
   );

   modport slave (
      input  req, wen, addr, wdata,
      output ack, rdata
   );
endinterface

// File: rtl/core_preempt_unit.sv
// Services the preempting decoder actions (jump, load/store, halt): PC
// redirect, data-memory handshake, load write-back and the halted state.
module core_preempt_unit #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 16,
   parameter int TIMEOUT = 255
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              jump_en_i,
   input  logic              jump_kind_i,
   input  logic              lsu_en_i,
   input  logic              lsu_wen_i,
   input  logic              lsu_kind_i,
   input  logic              halt_i,
   input  logic [15:0]       instr_i,
   input  logic [DATA_W-1:0] reg_a_i,
   input  logic [DATA_W-1:0] reg_b_i,
   input  logic              resume_i,
   core_preempt_unit_if.master mem,
   output logic              arf_wen_o,
   output logic [3:0]        arf_waddr_o,
   output logic [DATA_W-1:0] arf_wdata_o,
   output logic              pc_load_o,
   output logic [ADDR_W-1:0] pc_next_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              halted_o,
   output logic              fault_o
);

   typedef enum logic [1:0] {
      IDLE,
      MEM_REQ,
      WB,
      HALTED
   } state_t;

   localparam int CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam int CNT_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_I);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic [3:0]       rd;

   logic take_halt;
   logic take_jump;
   logic take_lsu;
   logic timed_out;
   logic load_ack;

   logic pc_load_d;
   logic done_d;
   logic arf_wen_d;
   logic mem_req_d;
   logic halted_d;
   logic fault_d;

   logic [ADDR_W-1:0] jump_target;
   logic [ADDR_W-1:0] lsu_addr;

   logic unused_bits;
   assign unused_bits = ^{instr_i[15:12], reg_b_i[DATA_W-1:ADDR_W], reg_a_i[DATA_W-1:ADDR_W]};

   // Requests only count in IDLE; halt beats jump beats load/store.
   assign take_halt = (state == IDLE) && halt_i;
   assign take_jump = (state == IDLE) && !halt_i && jump_en_i;
   assign take_lsu  = (state == IDLE) && !halt_i && !jump_en_i && lsu_en_i;

   assign timed_out = (TIMEOUT != 0) && (cnt == CNT_LAST);
   assign load_ack  = (state == MEM_REQ) && mem.ack && !mem.wen;

   assign jump_target = jump_kind_i ? instr_i[ADDR_W-1:0] : reg_a_i[ADDR_W-1:0];
   assign lsu_addr    = lsu_kind_i  ? instr_i[ADDR_W-1:0] : reg_b_i[ADDR_W-1:0];

   assign busy_o = (state != IDLE);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (take_halt) begin
               state_next = HALTED;
            end else if (take_lsu) begin
               state_next = MEM_REQ;
            end
         end
         MEM_REQ: begin
            if (mem.ack) begin
               state_next = mem.wen ? IDLE : WB;
            end else if (timed_out) begin
               state_next = HALTED;
            end
         end
         WB: begin
            state_next = IDLE;
         end
         HALTED: begin
            if (resume_i && !fault_o) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Next values of the registered outputs; they land one cycle after the event.
   always_comb begin
      pc_load_d = take_jump;
      done_d    = take_jump
                | ((state == MEM_REQ) && mem.ack)
                | ((state == HALTED) && resume_i && !fault_o);
      arf_wen_d = load_ack && (rd != 4'd0);
      mem_req_d = (state_next == MEM_REQ);
      halted_d  = (state_next == HALTED);
      fault_d   = fault_o | ((state == MEM_REQ) && !mem.ack && timed_out);
      cnt_next  = '0;
      if ((state == MEM_REQ) && !mem.ack) begin
         cnt_next = cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pc_load_o   <= 1'b0;
         pc_next_o   <= '0;
         done_o      <= 1'b0;
         arf_wen_o   <= 1'b0;
         arf_waddr_o <= '0;
         arf_wdata_o <= '0;
         halted_o    <= 1'b0;
         fault_o     <= 1'b0;
         mem.req     <= 1'b0;
         mem.wen     <= 1'b0;
         mem.addr    <= '0;
         mem.wdata   <= '0;
         rd          <= '0;
      end else begin
         pc_load_o <= pc_load_d;
         done_o    <= done_d;
         arf_wen_o <= arf_wen_d;
         halted_o  <= halted_d;
         fault_o   <= fault_d;
         mem.req   <= mem_req_d;
         if (take_jump) begin
            pc_next_o <= jump_target;
         end
         // Operands are frozen at acceptance so the decoder may move on.
         if (take_lsu) begin
            mem.wen   <= lsu_wen_i;
            mem.addr  <= lsu_addr;
            mem.wdata <= reg_a_i;
            rd        <= instr_i[11:8];
         end
         if (load_ack) begin
            arf_waddr_o <= rd;
            arf_wdata_o <= mem.rdata;
         end
      end
   end

endmodule

// File: tb/tb_core_preempt_unit.sv
// Scoreboard bench for core_preempt_unit: stimulus pushes expected output
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_core_preempt_unit;

   localparam int ADDR_W  = 8;
   localparam int DATA_W  = 16;
   localparam int TIMEOUT = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              jump_en = 1'b0;
   logic              jump_kind = 1'b0;
   logic              lsu_en = 1'b0;
   logic              lsu_wen = 1'b0;
   logic              lsu_kind = 1'b0;
   logic              halt = 1'b0;
   logic [15:0]       instr = '0;
   logic [DATA_W-1:0] reg_a = '0;
   logic [DATA_W-1:0] reg_b = '0;
   logic              resume = 1'b0;
   logic              arf_wen;
   logic [3:0]        arf_waddr;
   logic [DATA_W-1:0] arf_wdata;
   logic              pc_load;
   logic [ADDR_W-1:0] pc_next;
   logic              busy;
   logic              done;
   logic              halted;
   logic              fault;

   always #5 clk = ~clk;

   core_preempt_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

   core_preempt_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .jump_en_i   (jump_en),
      .jump_kind_i (jump_kind),
      .lsu_en_i    (lsu_en),
      .lsu_wen_i   (lsu_wen),
      .lsu_kind_i  (lsu_kind),
      .halt_i      (halt),
      .instr_i     (instr),
      .reg_a_i     (reg_a),
      .reg_b_i     (reg_b),
      .resume_i    (resume),
      .mem         (mem_bus.master),
      .arf_wen_o   (arf_wen),
      .arf_waddr_o (arf_waddr),
      .arf_wdata_o (arf_wdata),
      .pc_load_o   (pc_load),
      .pc_next_o   (pc_next),
      .busy_o      (busy),
      .done_o      (done),
      .halted_o    (halted),
      .fault_o     (fault)
   );

   typedef struct {
      bit          pc_load;
      logic [7:0]  pc_next;
      bit          done;
      bit          arf_wen;
      logic [3:0]  waddr;
      logic [15:0] wdata;
      bit          mem_start;
      bit          wen;
      logic [7:0]  addr;
      logic [15:0] sdata;
      bit          chk_sdata;
      bit          halted;
      bit          fault;
   } exp_t;

   exp_t sb[$];
   int   compared   = 0;
   int   mismatched = 0;

   function automatic exp_t ev_none();
      exp_t e;
      e.pc_load = 0; e.pc_next = '0; e.done = 0; e.arf_wen = 0; e.waddr = '0;
      e.wdata = '0; e.mem_start = 0; e.wen = 0; e.addr = '0; e.sdata = '0;
      e.chk_sdata = 0; e.halted = 0; e.fault = 0;
      return e;
   endfunction

   function automatic exp_t ev_jump(input logic [7:0] target);
      exp_t e = ev_none();
      e.pc_load = 1; e.pc_next = target; e.done = 1;
      return e;
   endfunction

   function automatic exp_t ev_mem(input bit wen, input logic [7:0] addr,
                                   input logic [15:0] sdata, input bit chk);
      exp_t e = ev_none();
      e.mem_start = 1; e.wen = wen; e.addr = addr; e.sdata = sdata; e.chk_sdata = chk;
      return e;
   endfunction

   function automatic exp_t ev_wb(input logic [3:0] waddr, input logic [15:0] wdata);
      exp_t e = ev_none();
      e.arf_wen = 1; e.waddr = waddr; e.wdata = wdata; e.done = 1;
      return e;
   endfunction

   function automatic exp_t ev_done();
      exp_t e = ev_none();
      e.done = 1;
      return e;
   endfunction

   function automatic exp_t ev_halt(input bit flt);
      exp_t e = ev_none();
      e.halted = 1; e.fault = flt;
      return e;
   endfunction

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input bit h, input bit j, input bit jk, input bit l,
                                 input bit lw, input bit lk, input logic [15:0] ins,
                                 input logic [15:0] ra, input logic [15:0] rb);
      halt = h; jump_en = j; jump_kind = jk; lsu_en = l; lsu_wen = lw; lsu_kind = lk;
      instr = ins; reg_a = ra; reg_b = rb;
      tick();
      halt = 0; jump_en = 0; lsu_en = 0;
   endtask

   // Monitor: one scoreboard entry per cycle that shows any output event.
   logic req_prev    = 1'b0;
   logic halted_prev = 1'b0;
   bit   mem_cur_valid = 0;
   exp_t mem_cur;

   always @(negedge clk) begin
      if (rst) begin
         req_prev      = 1'b0;
         halted_prev   = 1'b0;
         mem_cur_valid = 0;
      end else begin
         bit   mem_start;
         bit   halt_start;
         exp_t e;
         mem_start  = mem_bus.req && !req_prev;
         halt_start = halted && !halted_prev;
         if (pc_load || done || arf_wen || mem_start || halt_start) begin
            if (sb.size() == 0) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL unexpected_event: got pc_load=%b done=%b arf_wen=%b mem_start=%b halt_start=%b, expected none at %0t",
                        pc_load, done, arf_wen, mem_start, halt_start, $time);
            end else begin
               e = sb.pop_front();
               check_output("pc_load", 32'(pc_load), 32'(e.pc_load));
               check_output("done", 32'(done), 32'(e.done));
               check_output("arf_wen", 32'(arf_wen), 32'(e.arf_wen));
               check_output("mem_start", 32'(mem_start), 32'(e.mem_start));
               check_output("halt_start", 32'(halt_start), 32'(e.halted));
               check_output("fault", 32'(fault), 32'(e.fault));
               if (e.pc_load) check_output("pc_next", 32'(pc_next), 32'(e.pc_next));
               if (e.arf_wen) begin
                  check_output("arf_waddr", 32'(arf_waddr), 32'(e.waddr));
                  check_output("arf_wdata", 32'(arf_wdata), 32'(e.wdata));
               end
               if (e.mem_start) begin
                  mem_cur       = e;
                  mem_cur_valid = 1;
               end
            end
         end
         if (mem_bus.req && mem_cur_valid) begin
            check_output("mem_wen", 32'(mem_bus.wen), 32'(mem_cur.wen));
            check_output("mem_addr", 32'(mem_bus.addr), 32'(mem_cur.addr));
            if (mem_cur.chk_sdata) check_output("mem_wdata", 32'(mem_bus.wdata), 32'(mem_cur.sdata));
         end
         if (!mem_bus.req) mem_cur_valid = 0;
         req_prev    = mem_bus.req;
         halted_prev = halted;
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      mem_bus.ack   = 1'b0;
      mem_bus.rdata = '0;

      // Reset state
      rst = 1'b1;
      #2;
      check_output("rst_busy", 32'(busy), 0);
      check_output("rst_req", 32'(mem_bus.req), 0);
      check_output("rst_halted", 32'(halted), 0);
      check_output("rst_fault", 32'(fault), 0);
      tick();
      rst = 1'b0;
      tick();

      // Direct jump
      sb.push_back(ev_jump(8'h42));
      apply_stimulus(0, 1, 1, 0, 0, 0, 16'hC342, 16'h0000, 16'h0000);
      check_output("jump_busy", 32'(busy), 0);
      tick();
      check_output("jump_busy_after", 32'(busy), 0);

      // Direct load, ack on the third request cycle
      sb.push_back(ev_mem(0, 8'h20, 16'h0000, 0));
      sb.push_back(ev_wb(4'd5, 16'hBEEF));
      apply_stimulus(0, 0, 0, 1, 0, 1, 16'h8520, 16'h0000, 16'h0000);
      check_output("load_busy_c1", 32'(busy), 1);
      tick();
      check_output("load_req_c2", 32'(mem_bus.req), 1);
      tick();
      check_output("load_req_c3", 32'(mem_bus.req), 1);
      mem_bus.ack = 1'b1; mem_bus.rdata = 16'hBEEF;
      tick();
      mem_bus.ack = 1'b0; mem_bus.rdata = 16'h0000;
      check_output("load_req_wb", 32'(mem_bus.req), 0);
      check_output("load_busy_wb", 32'(busy), 1);
      tick();
      check_output("load_busy_idle", 32'(busy), 0);

      // Indirect store; operands scrambled after acceptance
      sb.push_back(ev_mem(1, 8'hFF, 16'h1234, 1));
      sb.push_back(ev_done());
      apply_stimulus(0, 0, 0, 1, 1, 0, 16'hB703, 16'h1234, 16'h00FF);
      instr = 16'h0000; reg_a = 16'hFFFF; reg_b = 16'h0011; lsu_wen = 0;
      tick();
      mem_bus.ack = 1'b1;
      tick();
      mem_bus.ack = 1'b0;
      check_output("store_busy_done", 32'(busy), 0);
      tick();

      // Halt + jump + lsu at once: halt wins
      sb.push_back(ev_halt(0));
      apply_stimulus(1, 1, 1, 1, 0, 1, 16'h8160, 16'h0000, 16'h0000);
      check_output("halt_halted", 32'(halted), 1);
      check_output("halt_pc_load", 32'(pc_load), 0);
      check_output("halt_req", 32'(mem_bus.req), 0);
      tick();
      sb.push_back(ev_done());
      resume = 1'b1;
      tick();
      resume = 1'b0;
      check_output("resume_halted", 32'(halted), 0);
      tick();

      // Load to R0: memory read happens, no ARF write
      sb.push_back(ev_mem(0, 8'h30, 16'h0000, 0));
      sb.push_back(ev_done());
      apply_stimulus(0, 0, 0, 1, 0, 1, 16'h8030, 16'h0000, 16'h0000);
      mem_bus.ack = 1'b1; mem_bus.rdata = 16'h5555;
      tick();
      mem_bus.ack = 1'b0;
      check_output("r0_busy_wb", 32'(busy), 1);
      tick();

      // Timeout after TIMEOUT request cycles without ack
      sb.push_back(ev_mem(0, 8'h40, 16'h0000, 0));
      sb.push_back(ev_halt(1));
      apply_stimulus(0, 0, 0, 1, 0, 1, 16'h8140, 16'h0000, 16'h0000);
      tick();
      tick();
      tick();
      check_output("tmo_req_c4", 32'(mem_bus.req), 1);
      tick();
      check_output("tmo_req_c5", 32'(mem_bus.req), 0);
      check_output("tmo_fault", 32'(fault), 1);
      check_output("tmo_halted", 32'(halted), 1);
      resume = 1'b1;
      tick();
      resume = 1'b0;
      tick();
      tick();
      check_output("tmo_resume_halted", 32'(halted), 1);
      check_output("tmo_resume_busy", 32'(busy), 1);

      // Clear fault, then reset in the middle of a request
      rst = 1'b1;
      #2;
      rst = 1'b0;
      tick();
      check_output("clr_fault", 32'(fault), 0);
      sb.push_back(ev_mem(0, 8'h50, 16'h0000, 0));
      apply_stimulus(0, 0, 0, 1, 0, 1, 16'h8250, 16'h0000, 16'h0000);
      tick();
      #2;
      rst = 1'b1;
      #1;
      check_output("mid_rst_req", 32'(mem_bus.req), 0);
      check_output("mid_rst_busy", 32'(busy), 0);
      check_output("mid_rst_arf_wen", 32'(arf_wen), 0);
      check_output("mid_rst_done", 32'(done), 0);
      tick();
      rst = 1'b0;
      tick();
      check_output("post_rst_busy", 32'(busy), 0);
      check_output("post_rst_req", 32'(mem_bus.req), 0);

      // Register-indirect jump after reset
      sb.push_back(ev_jump(8'hA5));
      apply_stimulus(0, 1, 0, 0, 0, 0, 16'h0000, 16'h77A5, 16'h0000);
      tick();
      tick();

      check_output("sb_empty", 32'(sb.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
